uart_tx_frame: RTL and testbench

Parametrised UART transmitter, successor to the fixed 8N1 serialiser. Configurable data width, bit period, parity and stop bits. Valid/ready input with a one-entry holding buffer, so back-to-back frames go out with no idle gap. Sits between a byte producer (FIFO or command sequencer) and the board TX pin.

---
 rtl/uart_pkg.sv | 24 ++
 rtl/uart_baud_tick.sv | 33 +++
 rtl/uart_tx_frame.sv | 178 +++++++++++++++++
 tb/tb_uart_tx_frame.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and helpers for the UART blocks
package uart_pkg;

  typedef enum logic [1:0] {
    PAR_NONE,
    PAR_EVEN,
    PAR_ODD
  } parity_t;

  // State names carry an ST_ prefix so they cannot collide with the PARITY parameter.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } tx_state_t;

  // Serial bits in one frame: start, data, optional parity, stop bits.
  function automatic int frame_len(input int data_bits, input parity_t parity, input int stop_bits);
    return 1 + data_bits + ((parity != PAR_NONE) ? 1 : 0) + stop_bits;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// rtl/uart_baud_tick.sv - bit-period timer, ticks on the last clk of each serial bit
module uart_baud_tick #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic restart,
  output logic tick
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  if (CLKS_PER_BIT < 2) begin : g_bad_clks
    $error("uart_baud_tick: CLKS_PER_BIT must be >= 2");
  end

  logic [CW-1:0] cnt;

  // Count clks within the current bit; restart pins the count to 0 on state entry.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (restart || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/uart_tx_frame.sv
// rtl/uart_tx_frame.sv - parametrised UART transmitter with one-entry holding buffer
module uart_tx_frame
  import uart_pkg::*;
#(
  parameter int      DATA_BITS    = 8,
  parameter int      CLKS_PER_BIT = 4,
  parameter parity_t PARITY       = PAR_NONE,
  parameter int      STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DATA_BITS-1:0] data_in,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic                 bit_out,
  output logic                 busy,
  output logic                 tx_done
);

  localparam int IW = $clog2(DATA_BITS + 1);
  localparam logic [IW-1:0] DATA_LAST = IW'(DATA_BITS - 1);
  localparam logic [IW-1:0] STOP_LAST = IW'(STOP_BITS - 1);

  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
    $error("uart_tx_frame: DATA_BITS must be 5..9");
  end
  if (CLKS_PER_BIT < 2) begin : g_bad_clks_per_bit
    $error("uart_tx_frame: CLKS_PER_BIT must be >= 2");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
    $error("uart_tx_frame: STOP_BITS must be 1 or 2");
  end
  if (PARITY != PAR_NONE && PARITY != PAR_EVEN && PARITY != PAR_ODD) begin : g_bad_parity
    $error("uart_tx_frame: PARITY must be PAR_NONE, PAR_EVEN or PAR_ODD");
  end

  tx_state_t            state;
  tx_state_t            next_state;
  logic                 buf_full;
  logic [DATA_BITS-1:0] buf_data;
  logic [DATA_BITS-1:0] shift_q;
  logic                 parity_q;
  logic [IW-1:0]        bit_idx;
  logic                 tick;
  logic                 restart;
  logic                 load;
  logic                 accept;
  logic                 line_c;
  logic                 done_c;

  assign in_ready = !buf_full;
  assign accept   = in_valid && in_ready;

  // The bit timer holds at 0 while idle and restarts on every state change.
  assign restart = (state == ST_IDLE) || (next_state != state);

  uart_baud_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud_tick (
    .clk    (clk),
    .reset  (reset),
    .restart(restart),
    .tick   (tick)
  );

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next state, shifter load strobe, and the line level for the current state.
  always_comb begin
    next_state = state;
    load       = 1'b0;
    line_c     = 1'b1;
    done_c     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (buf_full) begin
          next_state = ST_START;
          load       = 1'b1;
        end
      end
      ST_START: begin
        line_c = 1'b0;
        if (tick) begin
          next_state = ST_DATA;
        end
      end
      ST_DATA: begin
        line_c = shift_q[0];
        if (tick && (bit_idx == DATA_LAST)) begin
          next_state = (PARITY == PAR_NONE) ? ST_STOP : ST_PARITY;
        end
      end
      ST_PARITY: begin
        line_c = parity_q;
        if (tick) begin
          next_state = ST_STOP;
        end
      end
      ST_STOP: begin
        line_c = 1'b1;
        if (tick && (bit_idx == STOP_LAST)) begin
          done_c = 1'b1;
          if (buf_full) begin
            next_state = ST_START;
            load       = 1'b1;
          end else begin
            next_state = ST_IDLE;
          end
        end
      end
      default: begin
        next_state = ST_IDLE;
      end
    endcase
  end

  // Holding buffer: an accepted word waits here until the FSM pulls it into the shifter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      buf_full <= 1'b0;
      buf_data <= '0;
    end else begin
      if (accept) begin
        buf_data <= data_in;
      end
      if (accept) begin
        buf_full <= 1'b1;
      end else if (load) begin
        buf_full <= 1'b0;
      end
    end
  end

  // Shifter and parity are captured together so parity always matches the word on the line.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shift_q  <= '0;
      parity_q <= 1'b0;
    end else if (load) begin
      shift_q  <= buf_data;
      parity_q <= (PARITY == PAR_ODD) ? ~(^buf_data) : (^buf_data);
    end else if ((state == ST_DATA) && tick) begin
      shift_q <= shift_q >> 1;
    end
  end

  // Bit index counts data bits in DATA and stop bits in STOP; cleared on every state change.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bit_idx <= '0;
    end else if (next_state != state) begin
      bit_idx <= '0;
    end else if (tick && ((state == ST_DATA) || (state == ST_STOP))) begin
      bit_idx <= bit_idx + 1'b1;
    end
  end

  // Registered line outputs, all one clk behind the state so they stay mutually aligned.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bit_out <= 1'b1;
      busy    <= 1'b0;
      tx_done <= 1'b0;
    end else begin
      bit_out <= line_c;
      busy    <= (state != ST_IDLE);
      tx_done <= done_c;
    end
  end

endmodule

// File: tb/tb_uart_tx_frame.sv
// tb/tb_uart_tx_frame.sv - scoreboard bench for uart_tx_frame across four parameter sets
module tb_uart_tx_frame;
  import uart_pkg::*;

  localparam int NI  = 4;
  localparam int CPB = 4;

  // Instance 0: 8N1, 1: 8E1, 2: 8O1, 3: 7N2.
  function automatic int db_of(input int i);
    return (i == 3) ? 7 : 8;
  endfunction

  function automatic parity_t par_of(input int i);
    return (i == 1) ? PAR_EVEN : ((i == 2) ? PAR_ODD : PAR_NONE);
  endfunction

  function automatic int sb_of(input int i);
    return (i == 3) ? 2 : 1;
  endfunction

  logic                clk = 1'b0;
  logic                reset;
  logic [NI-1:0][8:0]  data_in;
  logic [NI-1:0]       in_valid;
  logic [NI-1:0]       in_ready;
  logic [NI-1:0]       bit_out;
  logic [NI-1:0]       busy;
  logic [NI-1:0]       tx_done;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int DB = db_of(g);
    uart_tx_frame #(
      .DATA_BITS   (DB),
      .CLKS_PER_BIT(CPB),
      .PARITY      (par_of(g)),
      .STOP_BITS   (sb_of(g))
    ) u_dut (
      .clk     (clk),
      .reset   (reset),
      .data_in (data_in[g][DB-1:0]),
      .in_valid(in_valid[g]),
      .in_ready(in_ready[g]),
      .bit_out (bit_out[g]),
      .busy    (busy[g]),
      .tx_done (tx_done[g])
    );
  end

  always #5 clk = ~clk;

  typedef struct packed {
    logic line;
    logic busy;
    logic done;
  } exp_t;

  exp_t exp_q[$];
  int   n_pass = 0;
  int   n_fail = 0;
  int   n_total = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected per-clk line/busy/done for one frame of the given instance.
  task automatic push_frame(input int idx, input logic [8:0] word);
    logic seq[$];
    logic par;
    int   nb;
    nb  = db_of(idx);
    par = (par_of(idx) == PAR_ODD);
    seq.push_back(1'b0);
    for (int i = 0; i < nb; i++) begin
      seq.push_back(word[i]);
      par = par ^ word[i];
    end
    if (par_of(idx) != PAR_NONE) seq.push_back(par);
    for (int i = 0; i < sb_of(idx); i++) seq.push_back(1'b1);
    for (int k = 0; k < seq.size(); k++) begin
      for (int c = 0; c < CPB; c++) begin
        exp_q.push_back('{line: seq[k], busy: 1'b1,
                          done: (k == seq.size() - 1) && (c == CPB - 1)});
      end
    end
  endtask

  task automatic push_idle(input int n);
    for (int i = 0; i < n; i++) exp_q.push_back('{line: 1'b1, busy: 1'b0, done: 1'b0});
  endtask

  // Pop one expectation per clk and compare; in_ready is expected low for samples in [rlo, rhi).
  task automatic watch(input int idx, input int n, input int rlo, input int rhi);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      if (exp_q.size() == 0) begin
        chk($sformatf("u%0d_scoreboard_empty[%0d]", idx, i), 0, 1);
      end else begin
        e = exp_q.pop_front();
        chk($sformatf("u%0d_line[%0d]", idx, i), bit_out[idx], e.line);
        chk($sformatf("u%0d_busy[%0d]", idx, i), busy[idx], e.busy);
        chk($sformatf("u%0d_tx_done[%0d]", idx, i), tx_done[idx], e.done);
        chk($sformatf("u%0d_in_ready[%0d]", idx, i), in_ready[idx],
            ((i >= rlo) && (i < rhi)) ? 0 : 1);
      end
      @(negedge clk);
    end
  endtask

  function automatic int frame_clks(input int idx);
    return CPB * frame_len(db_of(idx), par_of(idx), sb_of(idx));
  endfunction

  // Single isolated frame from an idle transmitter, including first-bit latency.
  task automatic send_frame(input int idx, input logic [8:0] word);
    int f;
    f = frame_clks(idx);
    @(negedge clk);
    chk($sformatf("u%0d_ready_before", idx), in_ready[idx], 1);
    data_in[idx]  = word;
    in_valid[idx] = 1'b1;
    push_frame(idx, word);
    @(negedge clk);
    in_valid[idx] = 1'b0;
    chk($sformatf("u%0d_ready_after_accept", idx), in_ready[idx], 0);
    chk($sformatf("u%0d_latency_line_n1", idx), bit_out[idx], 1);
    @(negedge clk);
    chk($sformatf("u%0d_latency_line_n2", idx), bit_out[idx], 1);
    chk($sformatf("u%0d_latency_busy_n2", idx), busy[idx], 0);
    @(negedge clk);
    watch(idx, f, 0, 0);
    chk($sformatf("u%0d_idle_line", idx), bit_out[idx], 1);
    chk($sformatf("u%0d_idle_busy", idx), busy[idx], 0);
    chk($sformatf("u%0d_drained", idx), exp_q.size(), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int f0;
    f0       = frame_clks(0);
    reset    = 1'b1;
    in_valid = '0;
    data_in  = '0;
    #1 reset = 1'b0;
    #1;
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("u%0d_reset_line", i), bit_out[i], 1);
      chk($sformatf("u%0d_reset_busy", i), busy[i], 0);
      chk($sformatf("u%0d_reset_ready", i), in_ready[i], 1);
      chk($sformatf("u%0d_reset_done", i), tx_done[i], 0);
    end
    repeat (2) @(negedge clk);
    reset = 1'b1;

    send_frame(0, 9'h0A5);
    send_frame(1, 9'h007);
    send_frame(2, 9'h007);
    send_frame(3, 9'h041);
    for (int i = 0; i < NI; i++) begin
      for (int r = 0; r < 2; r++) send_frame(i, 9'($urandom_range(0, 511)));
    end

    // Back-to-back: in_valid held across two words, no idle gap between frames.
    @(negedge clk);
    data_in[0]  = 9'h055;
    in_valid[0] = 1'b1;
    push_frame(0, 9'h055);
    @(negedge clk);
    chk("b2b_ready_low_after_first", in_ready[0], 0);
    data_in[0] = 9'h0AA;
    push_frame(0, 9'h0AA);
    @(negedge clk);
    chk("b2b_ready_after_load", in_ready[0], 1);
    @(negedge clk);
    in_valid[0] = 1'b0;
    watch(0, 2 * f0, 0, f0 - 1);
    chk("b2b_idle_busy", busy[0], 0);
    chk("b2b_drained", exp_q.size(), 0);

    // Accept landing on the final stop-bit edge with an empty buffer.
    @(negedge clk);
    chk("coinc_ready_before", in_ready[0], 1);
    data_in[0]  = 9'h03C;
    in_valid[0] = 1'b1;
    push_frame(0, 9'h03C);
    @(negedge clk);
    in_valid[0] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    fork
      watch(0, 2 * f0 + 1, f0 - 1, f0);
      begin
        repeat (f0 - 2) @(negedge clk);
        chk("coinc_ready_at_drive", in_ready[0], 1);
        data_in[0]  = 9'h0C3;
        in_valid[0] = 1'b1;
        push_idle(1);
        push_frame(0, 9'h0C3);
        @(negedge clk);
        in_valid[0] = 1'b0;
      end
    join
    push_idle(8);
    watch(0, 8, 0, 0);
    chk("coinc_drained", exp_q.size(), 0);

    // Reset 17 clks into a frame with a second word waiting in the buffer.
    @(negedge clk);
    data_in[0]  = 9'h0F7;
    in_valid[0] = 1'b1;
    push_frame(0, 9'h0F7);
    @(negedge clk);
    data_in[0] = 9'h03C;
    @(negedge clk);
    @(negedge clk);
    in_valid[0] = 1'b0;
    watch(0, 17, 0, 17);
    chk("rst_pre_line", bit_out[0], exp_q[0].line);
    #2 reset = 1'b0;
    #1;
    chk("rst_async_line", bit_out[0], 1);
    chk("rst_async_busy", busy[0], 0);
    chk("rst_async_ready", in_ready[0], 1);
    chk("rst_async_done", tx_done[0], 0);
    exp_q.delete();
    @(negedge clk);
    reset = 1'b1;
    chk("rst_release_ready", in_ready[0], 1);
    push_idle(3 * f0);
    @(negedge clk);
    watch(0, 3 * f0, 0, 0);
    chk("rst_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
